// File: rtl/apb_timer_slave.sv
// APB slave holding a 32-bit prescaled down-counter with auto-reload and a level IRQ.
// Access-phase wait states are fixed by WAIT_STATES to throttle the upstream bridge.
module apb_timer_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_LOAD  = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_e  state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        irqen_q, irqen_d;
    logic [31:0] load_q, load_d;
    logic [31:0] value_q, value_d;
    logic        expired_q, expired_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  presc_cnt_q, presc_cnt_d;
    logic        irq_q, irq_d;

    logic        ready;
    logic [31:0] offset;
    logic        addr_err;
    logic        wr_ok;
    logic        tick;
    logic        expire;
    logic [31:0] rdata;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = SETUP;
                    wait_d  = WAIT_INIT;
                end
            end
            SETUP, ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (!PENABLE) begin
                    state_d = SETUP;
                    wait_d  = WAIT_INIT;
                end else if (wait_q == 4'd0) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d  = wait_q - 4'd1;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-window addresses wrap to a large offset, so they fail the >0x10 test.
    assign offset   = PADDR - BASE_ADDR;
    assign addr_err = (offset > 32'h10) || (PADDR[1:0] != 2'b00) ||
                      (PWRITE && (offset == 32'h08));
    assign wr_ok    = ready && PWRITE && !addr_err;

    always_comb begin
        rdata = '0;
        case (offset)
            32'h00:  rdata = {29'd0, irqen_q, reload_q, en_q};
            32'h04:  rdata = load_q;
            32'h08:  rdata = value_q;
            32'h0C:  rdata = {31'd0, expired_q};
            32'h10:  rdata = {24'd0, presc_q};
            default: rdata = '0;
        endcase
    end

    assign PREADY  = ready;
    assign PSLVERR = ready && addr_err;
    assign PRDATA  = (ready && !addr_err && !PWRITE) ? rdata : '0;
    assign IRQ     = irq_q;

    assign tick = en_q && (presc_cnt_q == presc_q);

    always_comb begin
        en_d        = en_q;
        reload_d    = reload_q;
        irqen_d     = irqen_q;
        load_d      = load_q;
        value_d     = value_q;
        expired_d   = expired_q;
        presc_d     = presc_q;
        presc_cnt_d = (en_q && !tick) ? presc_cnt_q + 8'd1 : '0;
        expire      = 1'b0;
        irq_d       = expired_q & irqen_q;

        if (tick) begin
            if (value_q != '0) begin
                value_d = value_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (reload_q) value_d = load_q;
                else          en_d    = 1'b0;
            end
        end

        // Bus writes are applied after the tick so they override it; expiry beats W1C.
        if (wr_ok) begin
            case (offset)
                32'h00: begin
                    en_d     = PWDATA[0];
                    reload_d = PWDATA[1];
                    irqen_d  = PWDATA[2];
                end
                32'h04: begin
                    load_d      = PWDATA;
                    value_d     = PWDATA;
                    presc_cnt_d = '0;
                end
                32'h0C: if (PWDATA[0]) expired_d = 1'b0;
                32'h10: begin
                    presc_d     = PWDATA[7:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (expire) expired_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            en_q        <= 1'b0;
            reload_q    <= 1'b0;
            irqen_q     <= 1'b0;
            load_q      <= RESET_LOAD;
            value_q     <= RESET_LOAD;
            expired_q   <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            en_q        <= en_d;
            reload_q    <= reload_d;
            irqen_q     <= irqen_d;
            load_q      <= load_d;
            value_q     <= value_d;
            expired_q   <= expired_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomised APB bench for apb_timer_slave, checked against a register/timer model kept here.
module tb_apb_timer_slave;

    localparam int unsigned WS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] RLOAD = 32'h0000_00A5;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PWRITE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    // Reference model state, in register-map terms.
    bit          m_en, m_reload, m_irqen, m_exp, m_irq;
    logic [31:0] m_load, m_value;
    logic [7:0]  m_presc, m_pcnt;

    apb_timer_slave #(
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS),
        .RESET_LOAD (RLOAD)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .IRQ    (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic m_reset();
        m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
        m_load = RLOAD; m_value = RLOAD; m_presc = 8'd0; m_pcnt = 8'd0;
    endtask

    function automatic bit m_err(input logic [31:0] a, input bit w);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off < 0) || (off > 16) || (a % 4 != 0) || (w && off == 8);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        case (off)
            32'd0:   return {29'd0, m_irqen, m_reload, m_en};
            32'd4:   return m_load;
            32'd8:   return m_value;
            32'd12:  return {31'd0, m_exp};
            32'd16:  return {24'd0, m_presc};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one clock edge using the bus inputs present now.
    task automatic m_edge(input bit commit);
        bit          tick, fire, wr_ok;
        logic [31:0] off;
        bit          n_en, n_reload, n_irqen, n_exp, n_irq;
        logic [31:0] n_load, n_value;
        logic [7:0]  n_presc, n_pcnt;
        n_en = m_en; n_reload = m_reload; n_irqen = m_irqen; n_exp = m_exp;
        n_load = m_load; n_value = m_value; n_presc = m_presc;
        n_irq  = m_exp && m_irqen;
        tick   = m_en && (m_pcnt == m_presc);
        fire   = tick && (m_value == 0);
        n_pcnt = (m_en && !tick) ? m_pcnt + 8'd1 : 8'd0;
        wr_ok  = commit && PWRITE && !m_err(PADDR, 1'b1);
        off    = PADDR - BASE;
        if (tick && m_value != 0) n_value = m_value - 1;
        if (fire) begin
            n_exp = 1;
            if (m_reload) n_value = m_load;
            else          n_en = 0;
        end
        if (wr_ok) begin
            case (off)
                32'd0:  begin n_en = PWDATA[0]; n_reload = PWDATA[1]; n_irqen = PWDATA[2]; end
                32'd4:  begin n_load = PWDATA; n_value = PWDATA; n_pcnt = 8'd0; end
                32'd12: if (PWDATA[0] && !fire) n_exp = 0;
                32'd16: begin n_presc = PWDATA[7:0]; n_pcnt = 8'd0; end
                default: ;
            endcase
        end
        m_en = n_en; m_reload = n_reload; m_irqen = n_irqen; m_exp = n_exp; m_irq = n_irq;
        m_load = n_load; m_value = n_value; m_presc = n_presc; m_pcnt = n_pcnt;
    endtask

    task automatic cyc(input bit commit);
        @(posedge HCLK);
        m_edge(commit);
        #1;
    endtask

    task automatic chk_irq(input string tag);
        checks++;
        if (IRQ !== m_irq) begin
            errors++;
            $display("FAIL %s irq: got %b expected %b at %0t", tag, IRQ, m_irq, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        checks++;
        if (PREADY !== 1'b0 || PRDATA !== 32'd0 || PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL %s quiet: got ready=%b rdata=%h err=%b expected 0/0/0",
                     tag, PREADY, PRDATA, PSLVERR);
        end
    endtask

    task automatic idle(input int n);
        PSEL = 0; PENABLE = 0;
        for (int i = 0; i < n; i++) begin
            #3; chk_quiet("idle"); chk_irq("idle");
            cyc(0);
        end
    endtask

    // Full transfer; leaves PSEL high so a following call forms a back-to-back SETUP.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input string tag);
        bit          last, ee;
        logic [31:0] ed;
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
        #3; chk_quiet({tag, "_setup"}); chk_irq(tag);
        cyc(0);
        PENABLE = 1;
        for (int n = 0; n <= int'(WS); n++) begin
            last = (n == int'(WS));
            ee   = m_err(a, w);
            ed   = (last && !w && !ee) ? m_rd(a) : 32'd0;
            #3;
            checks++;
            if (PREADY !== last) begin
                errors++;
                $display("FAIL %s pready[%0d]: got %b expected %b", tag, n, PREADY, last);
            end
            checks++;
            if (PRDATA !== ed) begin
                errors++;
                $display("FAIL %s prdata[%0d] addr=%h: got %h expected %h", tag, n, a, PRDATA, ed);
            end
            checks++;
            if (PSLVERR !== (last && ee)) begin
                errors++;
                $display("FAIL %s pslverr[%0d] addr=%h: got %b expected %b", tag, n, a, PSLVERR, last && ee);
            end
            chk_irq(tag);
            cyc(last);
        end
    endtask

    task automatic abort_xfer(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        #3; chk_irq("abort"); cyc(0);
        PENABLE = 1;
        #3; chk_quiet("abort_access"); chk_irq("abort");
        cyc(0);
        idle(1);
    endtask

    task automatic test_reset();
        HRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        m_reset();
        #2; chk_quiet("reset"); chk_irq("reset");
        @(posedge HCLK); #1;
        HRESETn = 1;
        xfer(0, BASE + 32'h00, 0, "rst_ctrl");
        xfer(0, BASE + 32'h04, 0, "rst_load");
        xfer(0, BASE + 32'h08, 0, "rst_value");
        xfer(0, BASE + 32'h0C, 0, "rst_status");
        xfer(0, BASE + 32'h10, 0, "rst_presc");
        idle(1);
    endtask

    task automatic test_wait_states();
        xfer(1, BASE + 32'h00, 32'h6, "ws_wr_ctrl");
        idle(1);
        xfer(0, BASE + 32'h00, 0, "ws_rd_ctrl");
        xfer(1, BASE + 32'h00, 32'h0, "ws_clr_ctrl");
        idle(1);
    endtask

    task automatic test_error();
        xfer(1, BASE + 32'h04, 32'h1234_5678, "err_setload");
        xfer(1, BASE + 32'h08, $urandom, "err_wr_value");
        xfer(0, BASE + 32'h14, 0, "err_rd_14");
        xfer(1, BASE + 32'h14, $urandom, "err_wr_14");
        xfer(0, BASE + 32'h05, 0, "err_unaligned");
        xfer(1, BASE + 32'h100, 32'h7, "err_above");
        xfer(0, BASE - 32'h4, 0, "err_below");
        xfer(0, BASE + 32'h08, 0, "err_value_kept");
        idle(1);
    endtask

    task automatic test_oneshot();
        xfer(1, BASE + 32'h04, 32'd3, "os_load");
        xfer(1, BASE + 32'h10, 32'd1, "os_presc");
        xfer(1, BASE + 32'h0C, 32'd1, "os_clr");
        xfer(1, BASE + 32'h00, 32'h5, "os_ctrl");
        for (int i = 0; i < 4; i++) xfer(0, BASE + 32'h08, 0, "os_value");
        idle(4);
        xfer(0, BASE + 32'h00, 0, "os_ctrl_after");
        xfer(0, BASE + 32'h0C, 0, "os_status");
        xfer(1, BASE + 32'h0C, 32'd1, "os_w1c");
        idle(3);
    endtask

    task automatic test_autoreload();
        xfer(1, BASE + 32'h00, 32'h0, "ar_stop");
        xfer(1, BASE + 32'h04, 32'd2, "ar_load");
        xfer(1, BASE + 32'h10, 32'd0, "ar_presc");
        xfer(1, BASE + 32'h00, 32'h3, "ar_ctrl");
        for (int k = 0; k < 3; k++) begin
            idle(k);
            xfer(1, BASE + 32'h0C, 32'd1, "ar_w1c");
            xfer(0, BASE + 32'h0C, 0, "ar_status");
            xfer(0, BASE + 32'h08, 0, "ar_value");
        end
        xfer(1, BASE + 32'h00, 32'h0, "ar_off");
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            xfer(1, BASE + 32'h04, v, "b2b_wr_load");
            xfer(0, BASE + 32'h08, 0, "b2b_rd_value");
        end
        xfer(1, BASE + 32'h10, 32'h3C, "b2b_wr_presc");
        xfer(0, BASE + 32'h10, 0, "b2b_rd_presc");
        idle(1);
    endtask

    task automatic test_abort();
        abort_xfer(BASE + 32'h04, 32'hDEAD_BEEF);
        abort_xfer(BASE + 32'h00, 32'h7);
        xfer(0, BASE + 32'h04, 0, "abort_load_kept");
        xfer(0, BASE + 32'h00, 0, "abort_ctrl_kept");
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        bit          w;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: a = BASE + 32'(4 * $urandom_range(0, 4));
                5:             a = BASE + 32'h14;
                6:             a = BASE + 32'($urandom_range(0, 255));
                default:       a = $urandom;
            endcase
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            if (a == BASE + 32'h04) d = 32'($urandom_range(0, 12));
            if (a == BASE + 32'h10) d = 32'($urandom_range(0, 3));
            if (a == BASE + 32'h00) d = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) abort_xfer(a, d);
            else                           xfer(w, a, d, "rand");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(2);
    endtask

    task automatic test_reset_midaccess();
        xfer(1, BASE + 32'h10, 32'd0, "mr_presc");
        xfer(1, BASE + 32'h04, 32'd0, "mr_load");
        xfer(1, BASE + 32'h00, 32'h5, "mr_ctrl");
        idle(3);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = BASE;
        #3; chk_irq("mr_setup"); cyc(0);
        PENABLE = 1;
        for (int n = 0; n < int'(WS); n++) begin
            #3; chk_irq("mr_wait"); cyc(0);
        end
        #1;
        checks++;
        if (PREADY !== 1'b1 || PRDATA !== m_rd(BASE) || IRQ !== m_irq) begin
            errors++;
            $display("FAIL mr_pre: got ready=%b rdata=%h irq=%b expected 1/%h/%b",
                     PREADY, PRDATA, IRQ, m_rd(BASE), m_irq);
        end
        HRESETn = 0;
        #1;
        m_reset();
        chk_quiet("mr_reset"); chk_irq("mr_reset");
        PSEL = 0; PENABLE = 0;
        @(posedge HCLK); #1;
        HRESETn = 1;
        xfer(0, BASE + 32'h00, 0, "mr_ctrl_rd");
        xfer(0, BASE + 32'h04, 0, "mr_load_rd");
        xfer(0, BASE + 32'h08, 0, "mr_value_rd");
        idle(2);
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_error();
        test_oneshot();
        test_autoreload();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_midaccess();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
